// File: rtl/bulls_cows_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bulls_cows_game_ctrl
// Purpose  : Game sequencer for the two-digit hex bulls-and-cows scorer.
// Revision : 1.0  initial release
// ============================================================================
module bulls_cows_game_ctrl #(
    parameter int MAX_TRIES = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_secret,
    input  logic [7:0]       secret_in,
    input  logic             guess_valid,
    input  logic [7:0]       guess_in,
    output logic             guess_ready,
    output logic [7:0]       score_s,
    output logic [7:0]       score_g,
    input  logic [1:0]       score_bulls,
    input  logic [1:0]       score_cows,
    output logic             result_valid,
    output logic [1:0]       bulls,
    output logic [1:0]       cows,
    output logic [CNT_W-1:0] attempts,
    output logic             secret_err,
    output logic             guess_err,
    output logic             win,
    output logic             lose
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SCORE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W:0] c_max_tries = (CNT_W+1)'(MAX_TRIES);

    state_t           r_state;
    logic [7:0]       r_secret;
    logic [7:0]       r_guess;
    logic [CNT_W:0]   w_att_inc;
    logic [CNT_W-1:0] w_att_sat;
    logic             w_secret_dup;
    logic             w_guess_dup;

    assign w_att_inc    = {1'b0, attempts} + (CNT_W+1)'(1);
    assign w_att_sat    = (&attempts) ? attempts : w_att_inc[CNT_W-1:0];
    assign w_secret_dup = (secret_in[7:4] == secret_in[3:0]);
    assign w_guess_dup  = (guess_in[7:4] == guess_in[3:0]);

    assign guess_ready = (r_state == S_WAIT);
    assign score_s     = r_secret;
    assign score_g     = r_guess;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_secret     <= 8'h00;
            r_guess      <= 8'h00;
            result_valid <= 1'b0;
            bulls        <= 2'd0;
            cows         <= 2'd0;
            attempts     <= '0;
            secret_err   <= 1'b0;
            guess_err    <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            secret_err   <= 1'b0;
            guess_err    <= 1'b0;
            // A new secret overrides any in-flight scoring and the same-cycle guess.
            if (set_secret) begin
                if (w_secret_dup) begin
                    secret_err <= 1'b1;
                    r_state    <= S_IDLE;
                end else begin
                    r_secret <= secret_in;
                    attempts <= '0;
                    bulls    <= 2'd0;
                    cows     <= 2'd0;
                    win      <= 1'b0;
                    lose     <= 1'b0;
                    r_state  <= S_WAIT;
                end
            end else begin
                case (r_state)
                    S_WAIT: begin
                        if (guess_valid) begin
                            if (w_guess_dup) begin
                                guess_err <= 1'b1;
                            end else begin
                                r_guess <= guess_in;
                                r_state <= S_SCORE;
                            end
                        end
                    end
                    S_SCORE: begin
                        bulls        <= score_bulls;
                        cows         <= score_cows;
                        attempts     <= w_att_sat;
                        result_valid <= 1'b1;
                        if (score_bulls == 2'd2) begin
                            win     <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_att_inc == c_max_tries) begin
                            lose    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bulls_cows_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bulls_cows_game_ctrl
// Purpose  : Scoreboard bench for the bulls-and-cows game sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_bulls_cows_game_ctrl;

    localparam int MAX_TRIES = 8;
    localparam int CNT_W     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             set_secret;
    logic [7:0]       secret_in;
    logic             guess_valid;
    logic [7:0]       guess_in;
    logic             guess_ready;
    logic [7:0]       score_s;
    logic [7:0]       score_g;
    logic [1:0]       score_bulls;
    logic [1:0]       score_cows;
    logic             result_valid;
    logic [1:0]       bulls;
    logic [1:0]       cows;
    logic [CNT_W-1:0] attempts;
    logic             secret_err;
    logic             guess_err;
    logic             win;
    logic             lose;

    typedef struct {
        logic [1:0] b;
        logic [1:0] c;
        logic [3:0] a;
        logic       w;
        logic       l;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_wait   = 1'b0;
    int   exp_att  = 0;
    logic [7:0] m_secret = 8'h00;

    bulls_cows_game_ctrl #(.MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .set_secret(set_secret), .secret_in(secret_in),
        .guess_valid(guess_valid), .guess_in(guess_in), .guess_ready(guess_ready),
        .score_s(score_s), .score_g(score_g), .score_bulls(score_bulls),
        .score_cows(score_cows), .result_valid(result_valid), .bulls(bulls),
        .cows(cows), .attempts(attempts), .secret_err(secret_err),
        .guess_err(guess_err), .win(win), .lose(lose)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] f_bulls(input logic [7:0] s, input logic [7:0] g);
        return 2'((s[7:4] == g[7:4]) ? 1 : 0) + 2'((s[3:0] == g[3:0]) ? 1 : 0);
    endfunction

    function automatic logic [1:0] f_cows(input logic [7:0] s, input logic [7:0] g);
        return 2'((s[7:4] == g[3:0]) ? 1 : 0) + 2'((s[3:0] == g[7:4]) ? 1 : 0);
    endfunction

    // External scorer stand-in
    assign score_bulls = f_bulls(score_s, score_g);
    assign score_cows  = f_cows(score_s, score_g);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(result_valid), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_cycle",    32'(cyc),      32'(e.cyc));
                check("res_bulls",    32'(bulls),    32'(e.b));
                check("res_cows",     32'(cows),     32'(e.c));
                check("res_attempts", 32'(attempts), 32'(e.a));
                check("res_win",      32'(win),      32'(e.w));
                check("res_lose",     32'(lose),     32'(e.l));
            end
        end
    end

    task automatic do_secret(input logic [7:0] s);
        logic bad;
        bad        = (s[7:4] == s[3:0]);
        set_secret = 1'b1;
        secret_in  = s;
        @(negedge clk);
        set_secret = 1'b0;
        check("secret_err", 32'(secret_err), 32'(bad));
        if (bad) begin
            m_wait = 1'b0;
            check("secret_kept", 32'(score_s), 32'(m_secret));
        end else begin
            m_wait   = 1'b1;
            exp_att  = 0;
            m_secret = s;
            check("score_s",      32'(score_s),  32'(s));
            check("att_cleared",  32'(attempts), 32'(0));
            check("win_cleared",  32'(win),      32'(0));
            check("lose_cleared", 32'(lose),     32'(0));
        end
        check("ready_after_secret", 32'(guess_ready), 32'(m_wait));
    endtask

    task automatic do_guess(input logic [7:0] g);
        logic acc, ok;
        exp_t e;
        acc = m_wait;
        ok  = (g[7:4] != g[3:0]);
        check("guess_ready", 32'(guess_ready), 32'(acc));
        guess_valid = 1'b1;
        guess_in    = g;
        if (acc && ok) begin
            e.b     = f_bulls(m_secret, g);
            e.c     = f_cows(m_secret, g);
            e.a     = 4'(exp_att + 1);
            e.w     = (e.b == 2'd2);
            e.l     = !e.w && (exp_att + 1 == MAX_TRIES);
            e.cyc   = cyc + 2;
            exp_att = exp_att + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        guess_valid = 1'b0;
        check("guess_err", 32'(guess_err), 32'(acc && !ok));
        if (acc && ok) begin
            check("score_g",        32'(score_g),     32'(g));
            check("ready_in_score", 32'(guess_ready), 32'(0));
            @(negedge clk);
            m_wait = !(e.w || e.l);
        end
    endtask

    initial begin
        rst = 1'b1; set_secret = 1'b0; secret_in = 8'h00;
        guess_valid = 1'b0; guess_in = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready",    32'(guess_ready),  32'(0));
        check("rst_score_s",  32'(score_s),      32'(0));
        check("rst_score_g",  32'(score_g),      32'(0));
        check("rst_attempts", 32'(attempts),     32'(0));
        check("rst_outputs",  32'({result_valid, bulls, cows, secret_err, guess_err, win, lose}), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        do_guess(8'h12);                   // IDLE: ignored, no error
        do_secret(8'h3A);
        do_guess(8'h35);
        check("g35_bulls", 32'(bulls), 32'(1));
        check("g35_cows",  32'(cows),  32'(0));
        do_guess(8'h53);
        check("g53_cows",  32'(cows),  32'(1));
        do_guess(8'hA3);
        check("gA3_cows",  32'(cows),  32'(2));
        check("gA3_att",   32'(attempts), 32'(3));
        do_guess(8'h3A);
        check("win",       32'(win),  32'(1));
        check("win_ready", 32'(guess_ready), 32'(0));
        repeat (3) do_guess(8'h35);        // DONE: ignored
        check("done_hold_att", 32'(attempts), 32'(4));
        check("done_hold_win", 32'(win),      32'(1));

        do_secret(8'h44);
        @(negedge clk);
        check("secret_err_pulse", 32'(secret_err), 32'(0));
        do_secret(8'h3A);
        do_guess(8'h77);
        check("dup_guess_att",   32'(attempts),    32'(0));
        check("dup_guess_ready", 32'(guess_ready), 32'(1));
        check("dup_guess_reg",   32'(score_g),     32'(8'h3A));

        for (int i = 0; i < MAX_TRIES; i++) do_guess(8'h12);
        check("lose",       32'(lose),        32'(1));
        check("lose_att",   32'(attempts),    32'(MAX_TRIES));
        check("lose_ready", 32'(guess_ready), 32'(0));
        do_guess(8'h12);

        // Secret replaced while the guess is being scored
        do_secret(8'h3A);
        do_guess(8'hA3);
        guess_valid = 1'b1; guess_in = 8'h35;
        @(negedge clk);
        guess_valid = 1'b0;
        set_secret = 1'b1; secret_in = 8'h5C;
        @(negedge clk);
        set_secret = 1'b0;
        m_secret = 8'h5C; exp_att = 0; m_wait = 1'b1;
        check("abort_ready", 32'(guess_ready), 32'(1));
        check("abort_att",   32'(attempts),    32'(0));
        check("abort_s",     32'(score_s),     32'(8'h5C));
        repeat (3) @(negedge clk);
        do_guess(8'hC5);
        check("c5_cows", 32'(cows), 32'(2));

        #1 rst = 1'b1;
        #1;
        check("async_rst_outputs", 32'({result_valid, bulls, cows, attempts, secret_err, guess_err, win, lose}), 32'(0));
        check("async_rst_regs",    32'({score_s, score_g, guess_ready}), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bulls_cows_game_ctrl.md
Name: bulls_cows_game_ctrl

Overview:
Sequencing controller for the two-digit hex bulls-and-cows scorer. It holds the secret and the latched guess, drives the scorer's s/g inputs, and samples the scorer's combinational bulls/cows result. It also counts attempts and runs the game to a win or lose end state. It sits between the user-input front end (switch/button debouncers) and the display logic.

Parameters:
MAX_TRIES, 8, number of scored guesses before the game is lost; legal range 1..15
CNT_W, 4, width of the attempt counter; must hold MAX_TRIES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
set_secret  in  1  one-cycle pulse: load secret_in and start a new game
secret_in  in  8  secret, two 4-bit digits [7:4],[3:0]
guess_valid  in  1  guess offered this cycle
guess_in  in  8  guess, two 4-bit digits
guess_ready  out  1  controller accepts a guess this cycle
score_s  out  8  to scorer s input (= secret register)
score_g  out  8  to scorer g input (= guess register)
score_bulls  in  2  from scorer
score_cows  in  2  from scorer
result_valid  out  1  one-cycle pulse: bulls/cows hold a new result
bulls  out  2  registered bulls of last scored guess
cows  out  2  registered cows of last scored guess
attempts  out  CNT_W  scored guesses this game
secret_err  out  1  one-cycle pulse: secret rejected (equal digits)
guess_err  out  1  one-cycle pulse: guess rejected (equal digits)
win  out  1  level: game won
lose  out  1  level: game lost

Behaviour:
- Async reset values: all outputs 0; secret and guess registers 0x00; state IDLE.
- States: IDLE (no valid secret), WAIT (guess_ready=1), SCORE, DONE. guess_ready=1 only in WAIT.
- set_secret, accepted in any state, has priority over everything else:
  - secret_in[7:4]==secret_in[3:0]: secret_err pulses next cycle; state goes to IDLE; secret unchanged.
  - otherwise: secret loaded; attempts, bulls, cows, win, lose cleared; state goes to WAIT.
  - Same-cycle guess_valid is ignored.
  - set_secret during SCORE aborts the scoring; no result_valid is issued.
- Guess handshake: a guess is taken on cycle N when guess_valid && guess_ready.
  - guess_in[7:4]==guess_in[3:0]: guess_err pulses at N+1; the guess is not counted; state stays WAIT; guess register unchanged.
  - otherwise: guess register loaded at edge N; state goes to SCORE for cycle N+1; score_g presents the guess during N+1.
  - At the end of N+1, score_bulls/score_cows are registered into bulls/cows, attempts is incremented, and result_valid pulses during N+2.
  - Guess-to-result latency is 2 cycles; the next guess can be accepted at N+2.
- Transition out of SCORE (evaluated at the end of N+1, in priority order):
  - score_bulls==2: win=1, state DONE.
  - else if attempts+1==MAX_TRIES: lose=1, state DONE.
  - else: state WAIT.
- DONE: guess_ready=0 and guess_valid is ignored. win/lose, bulls, cows and attempts hold until set_secret or rst.
- In IDLE, guess_valid is ignored with no error. attempts saturates and never wraps.
- score_s always equals the secret register; score_g always equals the guess register.

Test Plan:
- Reset, then set_secret with 0x3A -> WAIT, guess_ready=1, score_s=0x3A, attempts=0.
- Secret 0x3A; guess 0x35 at N -> result_valid at N+2 with bulls=1, cows=0, attempts=1. Guess 0x53 -> bulls=0, cows=1. Guess 0xA3 -> bulls=0, cows=2, attempts=3.
- Secret 0x3A; guess 0x3A -> bulls=2, win=1, DONE, guess_ready=0; a later guess_valid produces no response.
- set_secret 0x44 -> secret_err pulse, state IDLE. Then guess 0x77 in WAIT (after a valid secret) -> guess_err pulse, attempts unchanged, guess_ready stays 1.
- MAX_TRIES=8, secret 0x3A; eight guesses of 0x12 -> each bulls=0, cows=0; after the 8th, lose=1, attempts=8, DONE.
- set_secret 0x5C during SCORE -> no result_valid, attempts=0, state WAIT. Assert rst mid-game -> all outputs 0 immediately, without waiting for a clock edge.
